// File: rtl/rv_mul_pkg.sv
// Shared encodings for the digit-serial RV32M multiplier.
package rv_mul_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_HSS = 2'b01,
        MUL_HSU = 2'b10,
        MUL_HUU = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mul_state_e;

    // Digit index width; a single-digit configuration still needs a 1-bit index.
    function automatic int idx_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    function automatic logic a_is_signed(input logic [1:0] op);
        return (op == MUL_HSS) || (op == MUL_HSU);
    endfunction

    function automatic logic b_is_signed(input logic [1:0] op);
        return (op == MUL_HSS);
    endfunction

endpackage

// File: rtl/rv_mul_pp.sv
// Digit select and shifted partial product for one (i, j) digit pair.
module rv_mul_pp
    import rv_mul_pkg::*;
#(
    parameter  int DPWIDTH = 32,
    parameter  int DIGIT   = 8,
    localparam int IW      = idx_w(DPWIDTH / DIGIT)
) (
    input  logic [DPWIDTH-1:0]   ma,
    input  logic [DPWIDTH-1:0]   mb,
    input  logic [IW-1:0]        i,
    input  logic [IW-1:0]        j,
    output logic [2*DPWIDTH-1:0] pp
);

    logic [DIGIT-1:0]   da;
    logic [DIGIT-1:0]   db;
    logic [2*DIGIT-1:0] prod;

    always_comb begin
        da   = ma[int'(i) * DIGIT +: DIGIT];
        db   = mb[int'(j) * DIGIT +: DIGIT];
        prod = {{DIGIT{1'b0}}, da} * {{DIGIT{1'b0}}, db};
        pp   = (2*DPWIDTH)'(prod) << (DIGIT * (int'(i) + int'(j)));
    end

endmodule

// File: rtl/rv_mul_seq.sv
// Digit-serial RV32M multiplier (MUL/MULH/MULHSU/MULHU): magnitude multiply,
// one digit pair per cycle, sign fix-up at the end.
//
// state  | meaning
// S_IDLE | waiting for start; operands captured as magnitudes on start
// S_CALC | accumulate one digit-pair partial product per cycle
// S_FIX  | apply sign, select high/low half into result
// S_DONE | done pulse, result valid
module rv_mul_seq
    import rv_mul_pkg::*;
#(
    parameter int DPWIDTH = 32,
    parameter int DIGIT   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [DPWIDTH-1:0] opa,
    input  logic [DPWIDTH-1:0] opb,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [DPWIDTH-1:0] result
);

    localparam int NDIG = DPWIDTH / DIGIT;
    localparam int IW   = idx_w(NDIG);
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    mul_state_e           state;
    mul_op_e              op_q;
    logic [DPWIDTH-1:0]   ma;
    logic [DPWIDTH-1:0]   mb;
    logic [IW-1:0]        i;
    logic [IW-1:0]        j;
    logic                 neg;
    logic [2*DPWIDTH-1:0] acc;
    logic [2*DPWIDTH-1:0] pp;
    logic [2*DPWIDTH-1:0] acc_fix;
    logic                 sa;
    logic                 sb;

    assign sa      = a_is_signed(op) & opa[DPWIDTH-1];
    assign sb      = b_is_signed(op) & opb[DPWIDTH-1];
    assign acc_fix = neg ? -acc : acc;

    rv_mul_pp #(.DPWIDTH(DPWIDTH), .DIGIT(DIGIT)) u_pp (
        .ma (ma),
        .mb (mb),
        .i  (i),
        .j  (j),
        .pp (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= MUL_LO;
            ma     <= '0;
            mb     <= '0;
            i      <= '0;
            j      <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // start takes priority over a coincident abort
                    if (start) begin
                        ma    <= sa ? -opa : opa;
                        mb    <= sb ? -opb : opb;
                        neg   <= sa ^ sb;
                        op_q  <= mul_op_e'(op);
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        busy  <= 1'b1;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc <= acc + pp;
                        if (j == LAST) begin
                            j <= '0;
                            if (i == LAST) begin
                                i     <= '0;
                                state <= S_FIX;
                            end else begin
                                i <= i + IW'(1);
                            end
                        end else begin
                            j <= j + IW'(1);
                        end
                    end
                end
                S_FIX: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc    <= acc_fix;
                        result <= (op_q == MUL_LO) ? acc_fix[DPWIDTH-1:0]
                                                   : acc_fix[2*DPWIDTH-1:DPWIDTH];
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
